// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable frequency divider family.
package freq_div_pkg;

    localparam int unsigned DEF_CNT_W = 27;
    localparam int unsigned DEF_DIV   = 2**26;

    // A divisor of zero is meaningless; treat it as divide-by-one.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == '0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/freq_div_prog.sv
// Run-time programmable clock divider: 50% divided clock, wrap strobe and live count.
// New divisors wait in a shadow register and take effect only at a period boundary.
module freq_div_prog
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_busy,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cnt_out
);

    localparam longint unsigned MAX_DIV = (64'd1 << CNT_W) - 64'd1;

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
        $error("freq_div_prog: CNT_W must be in 1..32");
    end
    if (DEFAULT_DIV == 0 || 64'(DEFAULT_DIV) > MAX_DIV) begin : g_bad_div
        $error("freq_div_prog: DEFAULT_DIV must be in 1..2**CNT_W-1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             busy_q, busy_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_new;
    logic             wrap;

    assign div_new = CNT_W'(clamp_div(32'(div_in)));
    assign wrap    = en && (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        busy_d    = busy_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (sync_clr || wrap) begin
            // Period boundary: a same-cycle load bypasses the shadow entirely.
            if (div_load) begin
                div_d  = div_new;
                busy_d = 1'b0;
            end else if (busy_q) begin
                div_d  = shadow_q;
                busy_d = 1'b0;
            end
            cnt_d = '0;
            if (sync_clr) begin
                clk_out_d = 1'b0;
            end else begin
                clk_out_d = ~clk_out_q;
                tick_d    = 1'b1;
            end
        end else begin
            if (en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (div_load) begin
                shadow_d = div_new;
                busy_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            shadow_q  <= '0;
            busy_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            busy_q    <= busy_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign cnt_out  = cnt_q;
    assign div_busy = busy_q;
    assign clk_out  = clk_out_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog in a reduced configuration (8-bit counter, default divisor 10).
module tb_freq_div_prog;

    localparam int unsigned W    = 8;
    localparam int unsigned DDEF = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sync_clr = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
    logic         div_busy;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] cnt_out;

    freq_div_prog #(.CNT_W(W), .DEFAULT_DIV(DDEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .div_in   (div_in),
        .div_load (div_load),
        .div_busy (div_busy),
        .clk_out  (clk_out),
        .tick     (tick),
        .cnt_out  (cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tick;
        bit clk_out;
        bit busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: position inside the current period, periods completed since the
    // last clear (its parity is the divided clock), active divisor, pending divisor.
    int m_pos, m_periods, m_div, m_pend;
    bit m_tick;

    task automatic model_reset();
        m_pos = 0; m_periods = 0; m_div = DDEF; m_pend = -1; m_tick = 0;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input bit e, input bit c, input bit l, input int d);
        int nd;
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1; en = e; sync_clr = c; div_load = l; div_in = W'(d);
        nd = (d == 0) ? 1 : d;
        m_tick = 0;
        if (c || (e && m_pos == m_div - 1)) begin
            if (l) m_div = nd;
            else if (m_pend >= 0) m_div = m_pend;
            m_pend = -1;
            m_pos = 0;
            if (c) m_periods = 0;
            else begin m_periods++; m_tick = 1; end
        end else begin
            if (e) m_pos++;
            if (l) m_pend = nd;
        end
        x.cnt = m_pos; x.tick = m_tick; x.clk_out = m_periods[0]; x.busy = (m_pend >= 0);
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each active edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("cnt_out", int'(cnt_out), x.cnt);
                check("tick", int'(tick), int'(x.tick));
                check("clk_out", int'(clk_out), int'(x.clk_out));
                check("div_busy", int'(div_busy), int'(x.busy));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_cnt", int'(cnt_out), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_busy", int'(div_busy), 0);

        idle(25);                                  // default divisor after reset
        step(1, 1, 1, 4); idle(20);                // D=4
        step(1, 1, 1, 5); idle(1);
        step(1, 0, 1, 2); idle(15);                // reload mid-period
        step(1, 0, 1, 0); idle(10);                // zero clamps to 1
        step(1, 1, 1, 3); idle(1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        idle(5);                                   // enable freeze
        step(1, 1, 1, 6); idle(3);
        step(1, 0, 1, 3); step(1, 1, 0, 0); idle(10);  // clear commits shadow
        step(1, 0, 1, 7); idle(2); step(1, 0, 1, 2);   // pending load then reset

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(cnt_out), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_clk_out", int'(clk_out), 0);
        check("async_rst_busy", int'(div_busy), 0);
        model_reset();
        // The posedge while reset is low is ignored; first step releases reset.
        idle(25);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(7) != 0), ($urandom_range(31) == 0),
                 ($urandom_range(7) == 0), int'($urandom_range(12)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
